// File: rtl/time_counter_if.sv
// Signal bundle for time_counter: time-setting inputs and time/display outputs.
// The setter (master) drives set_*; the counter (slave) drives cur_* and the status pulses.
interface time_counter_if;
  // set_load is a one-cycle request with no ready. A valid request is always taken.
  // An invalid request is answered by a one-cycle load_err pulse on the following cycle.
  logic       set_en;
  logic       set_load;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic [1:0] blink_sel;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       sec_tick;
  logic       day_wrap;
  logic       load_err;
  logic [5:0] disp_en;
  logic       chime;

  modport slave (
    input  set_en, set_load, set_hh, set_mm, set_ss, blink_sel,
    output cur_hh, cur_mm, cur_ss, sec_tick, day_wrap, load_err, disp_en, chime
  );

  modport master (
    output set_en, set_load, set_hh, set_mm, set_ss, blink_sel,
    input  cur_hh, cur_mm, cur_ss, sec_tick, day_wrap, load_err, disp_en, chime
  );
endinterface

// File: rtl/time_counter.sv
// BCD time-of-day counter with a load path, setting-mode blink, and an optional hourly chime.
// Defining TIME_COUNTER_CHIME_EN enables the chime output; otherwise chime is tied to 0.
module time_counter #(
  parameter int CLK_HZ = 50000000
) (
  input logic          clk,
  input logic          rst_n,
  time_counter_if.slave tc
);

  localparam int              PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_MAX   = PW'(CLK_HZ - 1);
  localparam int              HALF      = CLK_HZ / 2;
  localparam int              BW        = $clog2(HALF);
  localparam logic [BW-1:0]   BLINK_MAX = BW'(HALF - 1);

  logic [PW-1:0] presc_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;
  logic [7:0]    hh_q, mm_q, ss_q;
  logic [7:0]    hh_d, mm_d, ss_d;
  logic          sec_tick_q, day_wrap_q, load_err_q;
  logic [5:0]    disp_en_q;
  logic          tick, load_ok, load_take, hour_roll, day_roll;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign tick      = (presc_q == PRE_MAX) && !tc.set_en;
  assign load_ok   = digits_ok(tc.set_hh) && digits_ok(tc.set_mm) && digits_ok(tc.set_ss) &&
                     (tc.set_hh <= 8'h23) && (tc.set_mm <= 8'h59) && (tc.set_ss <= 8'h59);
  assign load_take = tc.set_load && load_ok;
  assign hour_roll = (mm_q == 8'h59) && (ss_q == 8'h59);
  assign day_roll  = hour_roll && (hh_q == 8'h23);

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (tick) begin
      if (ss_q == 8'h59) begin
        ss_d = 8'h00;
        if (mm_q == 8'h59) begin
          mm_d = 8'h00;
          hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
        end else begin
          mm_d = bcd_inc(mm_q);
        end
      end else begin
        ss_d = bcd_inc(ss_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      hh_q        <= 8'h00;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
      disp_en_q   <= 6'b111111;
    end else begin
      // A valid load resynchronises the second boundary; an invalid one leaves counting alone.
      if (load_take || tc.set_en)  presc_q <= '0;
      else if (presc_q == PRE_MAX) presc_q <= '0;
      else                         presc_q <= presc_q + 1'b1;

      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      if (load_take) begin
        hh_q <= tc.set_hh;
        mm_q <= tc.set_mm;
        ss_q <= tc.set_ss;
      end else begin
        hh_q <= hh_d;
        mm_q <= mm_d;
        ss_q <= ss_d;
      end

      sec_tick_q <= tick && !load_take;
      day_wrap_q <= tick && !load_take && day_roll;
      load_err_q <= tc.set_load && !load_ok;

      if (!tc.set_en || tc.blink_sel == 2'b11) disp_en_q <= 6'b111111;
      else begin
        case (tc.blink_sel)
          2'b00:   disp_en_q <= {blink_ph_q, blink_ph_q, 4'b1111};
          2'b01:   disp_en_q <= {2'b11, blink_ph_q, blink_ph_q, 2'b11};
          default: disp_en_q <= {4'b1111, blink_ph_q, blink_ph_q};
        endcase
      end
    end
  end

`ifdef TIME_COUNTER_CHIME_EN
  logic chime_q;
  always_ff @(posedge clk) begin
    if (!rst_n) chime_q <= 1'b0;
    else        chime_q <= tick && !load_take && hour_roll;
  end
  assign tc.chime = chime_q;
`else
  assign tc.chime = 1'b0;
`endif

  assign tc.cur_hh   = hh_q;
  assign tc.cur_mm   = mm_q;
  assign tc.cur_ss   = ss_q;
  assign tc.sec_tick = sec_tick_q;
  assign tc.day_wrap = day_wrap_q;
  assign tc.load_err = load_err_q;
  assign tc.disp_en  = disp_en_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed testbench for time_counter at CLK_HZ = 10: counting, wraps, loads, setting mode, reset.
module tb_time_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  logic [5:0] exp_disp;
  logic       ph;
  logic [1:0] sel;

`ifdef TIME_COUNTER_CHIME_EN
  localparam logic CHIME_EXP = 1'b1;
`else
  localparam logic CHIME_EXP = 1'b0;
`endif

  time_counter_if tc();

  time_counter #(.CLK_HZ(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    edge_n += n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    tc.set_load = 1'b1;
    tc.set_hh   = hh;
    tc.set_mm   = mm;
    tc.set_ss   = ss;
  endtask

  function automatic logic [23:0] cur_time();
    return {tc.cur_hh, tc.cur_mm, tc.cur_ss};
  endfunction

  initial begin
    rst_n        = 1'b0;
    tc.set_en    = 1'b0;
    tc.set_load  = 1'b0;
    tc.set_hh    = 8'h00;
    tc.set_mm    = 8'h00;
    tc.set_ss    = 8'h00;
    tc.blink_sel = 2'b11;
    step(2);
    check("reset_time", cur_time(), 24'h000000);
    check("reset_disp", tc.disp_en, 6'b111111);
    check("reset_pulses", {tc.sec_tick, tc.day_wrap, tc.load_err, tc.chime}, 4'b0000);

    // Free-running count from reset release
    rst_n  = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      check("run_sec_tick", tc.sec_tick, (i % 10) == 0);
      check("run_day_wrap", tc.day_wrap, 1'b0);
      if ((i % 10) == 0) check("run_cur_ss", tc.cur_ss, i / 10);
    end
    check("run_disp", tc.disp_en, 6'b111111);

    // Day wrap from 23:59:58
    load(8'h23, 8'h59, 8'h58);
    step(1);
    tc.set_load = 1'b0;
    check("load_time", cur_time(), 24'h235958);
    check("load_no_err", tc.load_err, 1'b0);
    check("load_no_tick", tc.sec_tick, 1'b0);
    step(10);
    check("t59_time", cur_time(), 24'h235959);
    check("t59_tick", tc.sec_tick, 1'b1);
    check("t59_wrap", {tc.day_wrap, tc.chime}, 2'b00);
    step(10);
    check("wrap_time", cur_time(), 24'h000000);
    check("wrap_tick", tc.sec_tick, 1'b1);
    check("wrap_day", tc.day_wrap, 1'b1);
    check("wrap_chime", tc.chime, CHIME_EXP);
    step(1);
    check("wrap_pulse_end", {tc.sec_tick, tc.day_wrap, tc.chime}, 3'b000);

    // Rejected loads
    load(8'h01, 8'h60, 8'h00);
    step(1);
    tc.set_load = 1'b0;
    check("bad_mm_err", tc.load_err, 1'b1);
    check("bad_mm_time", cur_time(), 24'h000000);
    step(1);
    check("bad_mm_err_end", tc.load_err, 1'b0);
    load(8'h01, 8'h02, 8'h1A);
    step(1);
    tc.set_load = 1'b0;
    check("bad_ss_err", tc.load_err, 1'b1);
    check("bad_ss_time", cur_time(), 24'h000000);
    step(1);
    load(8'h24, 8'h00, 8'h00);
    step(1);
    tc.set_load = 1'b0;
    check("bad_hh_err", tc.load_err, 1'b1);
    check("bad_hh_time", cur_time(), 24'h000000);
    step(1);
    check("bad_hh_err_end", tc.load_err, 1'b0);

    // Setting mode: time frozen, selected pair blinks every 5 cycles
    tc.set_en    = 1'b1;
    tc.blink_sel = 2'b01;
    for (int i = 1; i <= 50; i++) begin
      sel = (i > 40) ? 2'b10 : 2'b01;
      tc.blink_sel = sel;
      step(1);
      ph = (((edge_n - 1) / 5) % 2) == 0;
      exp_disp = (sel == 2'b01) ? {2'b11, ph, ph, 2'b11} : {4'b1111, ph, ph};
      check("set_disp", tc.disp_en, exp_disp);
      check("set_time", cur_time(), 24'h000000);
      check("set_no_tick", tc.sec_tick, 1'b0);
    end

    // Load coincident with a tick
    tc.set_en = 1'b0;
    step(9);
    check("pre_tick_quiet", tc.sec_tick, 1'b0);
    load(8'h12, 8'h34, 8'h56);
    step(1);
    tc.set_load = 1'b0;
    check("coinc_time", cur_time(), 24'h123456);
    check("coinc_no_tick", tc.sec_tick, 1'b0);
    check("coinc_disp", tc.disp_en, 6'b111111);
    step(9);
    check("coinc_quiet", tc.sec_tick, 1'b0);
    step(1);
    check("coinc_next_tick", tc.sec_tick, 1'b1);
    check("coinc_next_time", cur_time(), 24'h123457);

    // Load accepted while in setting mode
    tc.set_en = 1'b1;
    load(8'h05, 8'h06, 8'h07);
    step(1);
    tc.set_load = 1'b0;
    check("set_load_time", cur_time(), 24'h050607);
    step(12);
    check("set_load_frozen", cur_time(), 24'h050607);
    check("set_load_no_tick", tc.sec_tick, 1'b0);

    // Reset overrides a pending load
    tc.set_en = 1'b0;
    rst_n = 1'b0;
    load(8'h05, 8'h06, 8'h07);
    step(1);
    tc.set_load = 1'b0;
    check("rst_load_time", cur_time(), 24'h000000);
    check("rst_load_err", tc.load_err, 1'b0);
    check("rst_load_disp", tc.disp_en, 6'b111111);
    rst_n = 1'b1;
    step(9);
    check("rst_quiet", tc.sec_tick, 1'b0);
    step(1);
    check("rst_first_tick", tc.sec_tick, 1'b1);
    check("rst_first_ss", cur_time(), 24'h000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk cycles per second; even, >=4.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 set_en  in  1  setting mode active; time frozen while 1.
REQ-005 set_load  in  1  one-cycle request to load set_hh/set_mm/set_ss.
REQ-006 set_hh, set_mm, set_ss  in  8 each  packed-BCD time to load.
REQ-007 blink_sel  in  2  field being edited: 00 HH, 01 MM, 10 SS, 11 none.
REQ-008 cur_hh, cur_mm, cur_ss  out  8 each  current packed-BCD time.
REQ-009 sec_tick  out  1  one-cycle pulse per elapsed counted second.
REQ-010 day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-011 load_err  out  1  one-cycle pulse on rejected load.
REQ-012 disp_en  out  6  digit enables {hh10,hh1,mm10,mm1,ss10,ss1}; 1 = lit.
REQ-013 chime  out  1  one-cycle hourly pulse (see Configuration).

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 and wrap; internal tick when count = CLK_HZ-1 and set_en = 0.
REQ-015 While set_en = 1, prescaler SHALL hold 0 and time SHALL not advance.
REQ-016 On tick, ss SHALL increment in BCD; 59 -> 00 with carry to mm; mm 59 -> 00 with carry to hh; hh 23 -> 00.
REQ-017 cur_*, sec_tick, day_wrap SHALL update one cycle after the tick cycle; all outputs registered.
REQ-018 Load valid iff every nibble <= 9, set_hh <= 8'h23, set_mm <= 8'h59, set_ss <= 8'h59.
REQ-019 set_load valid: cur_* SHALL take set_* next cycle, prescaler cleared to 0, regardless of set_en.
REQ-020 set_load invalid: cur_* unchanged, prescaler unchanged, load_err = 1 for one cycle.
REQ-021 set_load and tick in same cycle: load wins; no sec_tick, no day_wrap, no chime.
REQ-022 blink phase SHALL toggle every CLK_HZ/2 cycles, free-running, independent of set_en.
REQ-023 disp_en = 6'b111111 when set_en = 0 or blink_sel = 11; else selected digit pair = blink phase, others 1; registered, one-cycle latency.
REQ-024 Loaded values SHALL never produce sec_tick or day_wrap.

Reset
REQ-025 rst_n = 0 at a rising edge: cur_hh/mm/ss = 8'h00, prescaler 0, blink phase 1, disp_en = 6'b111111, sec_tick = day_wrap = load_err = chime = 0.
REQ-026 Reset SHALL override set_load and tick in the same cycle; a load pending at reset is discarded.
REQ-027 Reset mid-count SHALL restart prescaler; first sec_tick CLK_HZ cycles after rst_n release.

Configuration
REQ-028 Macro TIME_COUNTER_CHIME_EN defined: chime = 1 for one cycle when a tick rolls mm:ss from 59:59 to 00:00 (including day wrap), registered like sec_tick.
REQ-029 Macro undefined: chime tied 0; no chime logic present; all other behaviour identical.

Verification (CLK_HZ = 10)
REQ-030 Reset release, set_en = 0, run 30 cycles -> sec_tick at cycles 10, 20, 30; cur_ss 01, 02, 03.
REQ-031 Load 23:59:58, run 20 cycles -> 23:59:59 then 00:00:00 with day_wrap = 1 and (CHIME_EN) chime = 1 same cycle.
REQ-032 set_load with set_mm = 8'h60 or set_ss = 8'h1A -> load_err one cycle, cur_* unchanged.
REQ-033 set_en = 1 for 50 cycles -> cur_* constant, no sec_tick; blink_sel = 01 -> disp_en[3:2] toggles every 5 cycles, other bits 1.
REQ-034 set_load (valid 12:34:56) coincident with tick -> next cycle 12:34:56, sec_tick = 0, next sec_tick 10 cycles later.
REQ-035 rst_n low during set_load at time 05:06:07 -> 00:00:00, load_err = 0, disp_en all 1.
